mem_responder: RTL and testbench
================================

# mem_responder

- Line-granular memory responder for the cache miss/write-through interface: 128-bit lines, 28-bit line address, `mem_ready` completion handshake.
- Each transaction completes after a fixed, parameterised latency, so cache and pipeline can be simulated and synthesised against realistic memory stall behaviour.
- Sits directly on the memory side of the instruction/data caches; one instance per cache.

## Interface
Parameters:
- `LATENCY`, 4: wait cycles before `mem_ready`. Legal range 1..15.
- `DEPTH_LOG2`, 8: log2 of the number of stored 128-bit lines.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on its rising edge.
- `proc_reset`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  read request; held by the requester until `mem_ready`.
- `mem_write`  in  1  write request; held by the requester until `mem_ready`.
- `mem_addr`  in  28  line address. Only `[DEPTH_LOG2-1:0]` indexes storage; upper bits are ignored, so lines alias.
- `mem_wdata`  in  128  write line data.
- `mem_rdata`  out  128  read line data; registered.
- `mem_ready`  out  1  one-cycle completion pulse; registered.

## Operation
- States:
  - IDLE: `mem_ready`=0.
  - BUSY: counting.
  - RESP: `mem_ready`=1 for exactly one cycle.
- IDLE, on an edge with `mem_read|mem_write` = 1:
  - latch op (write wins if both are high), index and wdata;
  - cnt <= `LATENCY`-1; go to BUSY.
- BUSY, on each edge:
  - If `mem_read|mem_write` is still high, re-latch op/index/wdata; the last asserted values win.
  - If the request has dropped, keep the latched values. There is no cancel.
  - If cnt==0, go to RESP, otherwise cnt--.
- Edge BUSY->RESP:
  - write: storage[index] <= wdata;
  - read: `mem_rdata` <= storage[index].
- RESP -> IDLE unconditionally.
  - During RESP, request inputs are ignored: the requester drops them combinationally on `mem_ready`.
  - A request asserted in the cycle after RESP is accepted normally. Back-to-back transactions have no dead cycle beyond RESP.
- `mem_rdata` holds its last loaded value outside RESP; writes do not change it.
- Read-after-write to the same line, in consecutive transactions, returns the newly written data.

## Timing
- Reset values: state=IDLE, `mem_ready`=0, `mem_rdata`=0, cnt=0, all storage lines=0.
- Latency: with the request first high in cycle 0 (IDLE), `mem_ready`=1 in cycle `LATENCY`+1 and the responder is IDLE again in cycle `LATENCY`+2.
  - Example: `LATENCY`=4 gives `mem_ready` in cycle 5.
- Minimum transaction spacing is `LATENCY`+2 cycles.
- Storage write commits at the BUSY->RESP edge, so a read accepted in the cycle after RESP sees it.
- `proc_reset` mid-transaction:
  - return to IDLE next edge with no `mem_ready` pulse;
  - a pending write is discarded;
  - all storage is cleared.
- Address wrap: `mem_addr`=`28'h0000100` with `DEPTH_LOG2`=8 accesses line 0.

## Configuration
- `MEM_RESP_LFSR_LAT_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed `16'hACE1`) steps once per accepted transaction.
  - Its bits [1:0] add 0..3 extra BUSY cycles to that transaction: initial cnt = `LATENCY`-1+lfsr[1:0].
  - Latency becomes `LATENCY`+1 .. `LATENCY`+4 cycles, and is deterministic after reset.
- Not defined: no LFSR, fixed latency exactly as in Timing.

## Test plan
- Reset, `LATENCY`=4; write `mem_addr`=5, `mem_wdata`=`128'h0123_4567_89AB_CDEF_0011_2233_4455_6677` -> single `mem_ready` pulse in cycle 5; then read addr 5 -> `mem_ready` in cycle 5 of that transaction, `mem_rdata` equal to the written line.
- Read from unwritten addr 9 immediately after reset -> `mem_rdata`=0 with `mem_ready`; no second pulse in the next cycle.
- Read miss then write on the very next cycle (cache write-miss flow): read addr 3, then write addr 3 with `mem_write` asserted in the cycle after `mem_ready` -> both complete, each with latency 5; a subsequent read returns the write data.
- Requester changes `mem_addr` from 0 to 7 during BUSY while holding `mem_write` -> data lands at line 7; a read of line 0 returns 0.
- Assert `proc_reset` in cycle 2 of a write to addr 4 -> no `mem_ready` pulse; next read of addr 4 returns 0 and takes the full latency.
- With `MEM_RESP_LFSR_LAT_EN`: 64 back-to-back reads -> every latency lies in 5..8, and the sequence matches across two runs after reset.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency line memory responder (optional MEM_RESP_LFSR_LAT_EN jitter)
module mem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [4:0] CNT_BASE = 5'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [4:0]              cnt;
    logic                    op_write;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [127:0]            wdata_q;
    logic [127:0]            storage [DEPTH];

    logic                    req;
    logic                    eff_write;
    logic [DEPTH_LOG2-1:0]   eff_idx;
    logic [127:0]            eff_wdata;
    logic [4:0]              cnt_init;
    logic                    unused_addr_bits;

    // Only the low address bits index storage; upper bits alias.
    assign unused_addr_bits = ^mem_addr[27:DEPTH_LOG2];

    // A still-asserted request overrides the latched values, so the last asserted values win at commit.
    always_comb begin
        req       = mem_read | mem_write;
        eff_write = req ? mem_write : op_write;
        eff_idx   = req ? mem_addr[DEPTH_LOG2-1:0] : idx;
        eff_wdata = req ? mem_wdata : wdata_q;
    end

`ifdef MEM_RESP_LFSR_LAT_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11; low two bits add 0..3 BUSY cycles.
    always_comb begin
        lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        cnt_init = CNT_BASE + {3'b000, lfsr[1:0]};
    end

    // LFSR advances once per accepted transaction.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            lfsr <= 16'hACE1;
        end else if (state == IDLE && req) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`else
    // Fixed latency.
    always_comb begin
        cnt_init = CNT_BASE;
    end
`endif

    // Transaction FSM: accept, count down, commit at BUSY->RESP, one-cycle ready pulse.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            cnt       <= '0;
            op_write  <= 1'b0;
            idx       <= '0;
            wdata_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (req) begin
                        op_write <= mem_write;
                        idx      <= mem_addr[DEPTH_LOG2-1:0];
                        wdata_q  <= mem_wdata;
                        cnt      <= cnt_init;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (req) begin
                        op_write <= mem_write;
                        idx      <= mem_addr[DEPTH_LOG2-1:0];
                        wdata_q  <= mem_wdata;
                    end
                    if (cnt == 5'd0) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        if (eff_write) begin
                            storage[eff_idx] <= eff_wdata;
                        end else begin
                            mem_rdata <= storage[eff_idx];
                        end
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                RESP: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: line contents, expected completion cycle, held read data.
    logic [127:0] model_mem [256];
    int           exp_ready_cyc = -1;
    bit           pend_read = 1'b0;
    logic [127:0] pend_rdata = '0;
    logic [127:0] exp_rdata = '0;
    bit           check_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Every cycle: ready only in the predicted cycle, rdata holds the last read result.
    always @(negedge clk) begin
        if (check_en) begin
            if (cyc == exp_ready_cyc && pend_read) exp_rdata = pend_rdata;
            check_int("mem_ready", int'(mem_ready), (cyc == exp_ready_cyc) ? 1 : 0);
            check128("mem_rdata", mem_rdata, exp_rdata);
        end
    end

    task automatic do_reset();
        proc_reset = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        proc_reset = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        exp_rdata     = '0;
        exp_ready_cyc = -1;
        pend_read     = 1'b0;
    endtask

    // One transaction starting now; optional address switch to a1 at cycle start+sw.
    task automatic txn(input bit wr, input logic [27:0] a0, input logic [27:0] a1, input int sw,
                       input logic [127:0] wd, output int lat, output logic [127:0] rd);
        int start;
        int line;
        start     = cyc;
        mem_read  = !wr;
        mem_write = wr;
        mem_addr  = a0;
        mem_wdata = wd;
        line = int'(((sw > 0) ? a1 : a0) % 28'd256);
        if (wr) begin
            model_mem[line] = wd;
            pend_read = 1'b0;
        end else begin
            pend_rdata = model_mem[line];
            pend_read  = 1'b1;
        end
        exp_ready_cyc = start + LAT + 1;
        lat = -1;
        rd  = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sw > 0 && cyc == start + sw) mem_addr = a1;
            if (mem_ready) begin
                lat = cyc - start;
                rd  = mem_rdata;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=no_ready required=ready (start %0d)", start);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] D3 = 128'hFEED_FACE_CAFE_F00D_1234_5678_9ABC_DEF0;
    localparam logic [127:0] D4 = 128'h5A5A_5A5A_A5A5_A5A5_0F0F_0F0F_F0F0_F0F0;

    int           lat;
    logic [127:0] rd;
`ifdef MEM_RESP_LFSR_LAT_EN
    int lat_a [64];
    int lat_b [64];
`endif

    initial begin
        do_reset();
`ifdef MEM_RESP_LFSR_LAT_EN
        for (int i = 0; i < 64; i++) begin
            txn(1'b0, 28'(i), 28'd0, 0, '0, lat, rd);
            lat_a[i] = lat;
            checks++;
            if (lat < LAT + 1 || lat > LAT + 4) begin
                errors++;
                $display("FAIL lfsr_range actual=%0d required=5..8 (txn %0d)", lat, i);
            end
        end
        do_reset();
        for (int i = 0; i < 64; i++) begin
            txn(1'b0, 28'(i), 28'd0, 0, '0, lat, rd);
            lat_b[i] = lat;
            check_int("lfsr_repeat", lat_b[i], lat_a[i]);
        end
`else
        check_en = 1'b1;
        check_int("reset_ready", int'(mem_ready), 0);
        check128("reset_rdata", mem_rdata, 128'h0);

        // Unwritten line reads zero, single pulse.
        txn(1'b0, 28'd9, 28'd0, 0, '0, lat, rd);
        check_int("rd9_lat", lat, 5);
        check128("rd9_data", rd, 128'h0);
        check_int("rd9_no_second_pulse", int'(mem_ready), 0);

        // Write then read back.
        txn(1'b1, 28'd5, 28'd0, 0, D1, lat, rd);
        check_int("wr5_lat", lat, 5);
        txn(1'b0, 28'd5, 28'd0, 0, '0, lat, rd);
        check_int("rd5_lat", lat, 5);
        check128("rd5_data", rd, D1);

        // Read miss followed immediately by write, then read.
        txn(1'b0, 28'd3, 28'd0, 0, '0, lat, rd);
        check_int("rd3_lat", lat, 5);
        check128("rd3_data", rd, 128'h0);
        txn(1'b1, 28'd3, 28'd0, 0, D2, lat, rd);
        check_int("wr3_lat", lat, 5);
        txn(1'b0, 28'd3, 28'd0, 0, '0, lat, rd);
        check128("rd3_after_wr", rd, D2);

        // Address moves 0 -> 7 during BUSY.
        txn(1'b1, 28'd0, 28'd7, 2, D3, lat, rd);
        check_int("wr_move_lat", lat, 5);
        txn(1'b0, 28'd7, 28'd0, 0, '0, lat, rd);
        check128("rd7_data", rd, D3);
        txn(1'b0, 28'd0, 28'd0, 0, '0, lat, rd);
        check128("rd0_data", rd, 128'h0);

        // Address wrap: 0x100 aliases line 0.
        txn(1'b1, 28'h0000100, 28'd0, 0, D4, lat, rd);
        txn(1'b0, 28'd0, 28'd0, 0, '0, lat, rd);
        check128("wrap_rd0", rd, D4);

        // Reset in cycle 2 of a write to line 4.
        mem_write = 1'b1;
        mem_addr  = 28'd4;
        mem_wdata = D2;
        pend_read = 1'b0;
        exp_ready_cyc = -1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        proc_reset = 1'b1;
        mem_write  = 1'b0;
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        exp_rdata = '0;
        check_int("rst_mid_ready", int'(mem_ready), 0);
        check128("rst_mid_rdata", mem_rdata, 128'h0);
        txn(1'b0, 28'd4, 28'd0, 0, '0, lat, rd);
        check_int("rd4_lat", lat, 5);
        check128("rd4_data", rd, 128'h0);
        txn(1'b0, 28'd5, 28'd0, 0, '0, lat, rd);
        check128("rd5_cleared", rd, 128'h0);
        check_en = 1'b0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
